// File: rtl/fifo_ser_pkg.sv
// Shared definitions for the FIFO word serializer: state encoding,
// default widths and the symbol parity helper.
// Optional feature macro: FIFO_SER_PARITY_EN (adds out_parity).
package fifo_ser_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_BYTE_W = 8;

    // Widest symbol the parity helper accepts; narrower symbols are zero-extended.
    localparam int MAX_SYM_W = 64;

    // Serializer FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_SHIFT = 2'd3;

    // XOR reduction of a symbol; zero extension does not change the result.
    function automatic logic sym_parity(input logic [MAX_SYM_W-1:0] sym);
        return ^sym;
    endfunction

endpackage

// File: rtl/fifo_ser_shifter.sv
// Word shift register and symbol counter for the FIFO word serializer.
// A load captures a full word; every shift retires the top symbol (MSB-first).
// The last flag is kept as a register so it is valid the cycle the symbol is.
// Optional feature macro: FIFO_SER_PARITY_EN (adds the parity output).
module fifo_ser_shifter
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int BYTE_W = DEFAULT_BYTE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data,
    output logic [BYTE_W-1:0] symbol,
    output logic              last
`ifdef FIFO_SER_PARITY_EN
    ,
    output logic              parity
`endif
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

    logic [DATA_W-1:0] shreg_r;
    logic [DATA_W-1:0] shreg_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              last_r;
    logic              last_nxt_s;

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Next-state of shift register, counter and last flag.
    always_comb begin
        shreg_nxt_s = shreg_r;
        cnt_nxt_s   = cnt_r;
        last_nxt_s  = last_r;
        if (load) begin
            shreg_nxt_s = data;
            cnt_nxt_s   = CNT_ZERO;
            last_nxt_s  = (NB == 1);
        end else if (shift) begin
            shreg_nxt_s = shreg_r << BYTE_W;
            if (last_r) begin
                // Word fully sent: park counter and flag until the next load.
                cnt_nxt_s  = CNT_ZERO;
                last_nxt_s = 1'b0;
            end else begin
                cnt_nxt_s  = cnt_inc_s;
                last_nxt_s = (cnt_inc_s == CNT_LAST);
            end
        end else begin
            shreg_nxt_s = shreg_r;
            cnt_nxt_s   = cnt_r;
            last_nxt_s  = last_r;
        end
    end

    // Shifter state registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_r <= '0;
            cnt_r   <= CNT_ZERO;
            last_r  <= 1'b0;
        end else begin
            shreg_r <= shreg_nxt_s;
            cnt_r   <= cnt_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    assign symbol = shreg_r[DATA_W-1 -: BYTE_W];
    assign last   = last_r;

`ifdef FIFO_SER_PARITY_EN
    logic parity_r;

    // Parity of the symbol that will be presented next cycle, so it moves with symbol.
    always_ff @(posedge clock) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else begin
            parity_r <= sym_parity(MAX_SYM_W'(shreg_nxt_s[DATA_W-1 -: BYTE_W]));
        end
    end

    assign parity = parity_r;
`endif

endmodule

// File: rtl/fifo_word_serializer.sv
// Reads words from an upstream FIFO and emits them as BYTE_W symbols,
// MSB-first, with a valid/ready handshake. One word is in flight at most:
// the read strobe is only raised in READ, and only when the FIFO is non-empty.
// Latency: trigger in cycle k -> fifo_read in k+1 -> out_valid in k+3.
// Optional feature macro: FIFO_SER_PARITY_EN (adds out_parity = ^out_data).
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int BYTE_W = DEFAULT_BYTE_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_read,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
`ifdef FIFO_SER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       fifo_read_r;
    logic       out_valid_r;
    logic       busy_r;
    logic       start_ok_s;
    logic       load_s;
    logic       shift_s;
    logic       sym_last_s;

    // A new read is allowed only when enabled and the FIFO has data right now.
    assign start_ok_s = enable && !fifo_empty;
    assign load_s     = (state_r == ST_WAIT);
    assign shift_s    = (state_r == ST_SHIFT) && out_ready;

    // FSM next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (out_ready && sym_last_s) begin
                    if (start_ok_s) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered control outputs, decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            fifo_read_r <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            fifo_read_r <= (state_nxt_s == ST_READ);
            out_valid_r <= (state_nxt_s == ST_SHIFT);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    fifo_ser_shifter #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_shifter (
        .clock  (clock),
        .reset  (reset),
        .load   (load_s),
        .shift  (shift_s),
        .data   (fifo_data),
        .symbol (out_data),
        .last   (sym_last_s)
`ifdef FIFO_SER_PARITY_EN
        ,
        .parity (out_parity)
`endif
    );

    assign fifo_read = fifo_read_r;
    assign out_valid = out_valid_r;
    assign out_last  = sym_last_s;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer with a small FIFO model and
// a symbol scoreboard. Optional macro: FIFO_SER_PARITY_EN.
module tb_fifo_word_serializer;

    logic       clock      = 1'b0;
    logic       reset      = 1'b1;
    logic       enable     = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic       out_ready  = 1'b0;
    logic       fifo_read;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       busy;
`ifdef FIFO_SER_PARITY_EN
    logic       out_parity;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] fifo_q[$];
    logic [7:0]  rx_data[$];
    logic        rx_last[$];
    int          rx_cyc[$];
    int cyc         = 0;
    int rd_pulses   = 0;
    int wide_pulses = 0;
    int underflows  = 0;
    int parity_errs = 0;

    always #5 clock = ~clock;

    fifo_word_serializer #(.DATA_W(32), .BYTE_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_read  (fifo_read),
        .fifo_data  (fifo_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
`ifdef FIFO_SER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: record handshakes before the edge, update the FIFO model after it.
    task automatic tick();
        logic rd_before;
        rd_before = fifo_read;
        if (out_valid && out_ready && !reset) begin
            rx_data.push_back(out_data);
            rx_last.push_back(out_last);
            rx_cyc.push_back(cyc);
        end
`ifdef FIFO_SER_PARITY_EN
        if (out_valid && (out_parity !== ^out_data)) parity_errs++;
`endif
        @(posedge clock);
        #1;
        cyc++;
        if (rd_before && !reset) begin
            rd_pulses++;
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            else underflows++;
        end
        if (rd_before && fifo_read) wide_pulses++;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_last.delete();
        rx_cyc.delete();
        rd_pulses = 0;
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int b;
        b = 0;
        while (rx_data.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(tag, 32'(rx_data.size()), 32'(n));
    endtask

    task automatic check_word(input string tag, input logic [31:0] w, input int base);
        logic [7:0] g;
        logic       l;
        for (int j = 0; j < 4; j++) begin
            g = (base + j < rx_data.size()) ? rx_data[base + j] : 8'hxx;
            l = (base + j < rx_last.size()) ? rx_last[base + j] : 1'bx;
            check($sformatf("%s_sym%0d", tag, j), 32'(g), 32'(w[31 - 8*j -: 8]));
            check($sformatf("%s_last%0d", tag, j), 32'(l), (j == 3) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int hi_rd;
        int hi_val;
        int hi_busy;
        int gap_errs;
        int stall_errs;

        // Reset state
        repeat (2) tick();
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        reset = 1'b0;

        // Empty FIFO with enable high: nothing may happen
        enable = 1'b1;
        hi_rd = 0; hi_val = 0; hi_busy = 0;
        repeat (10) begin
            tick();
            if (fifo_read) hi_rd++;
            if (out_valid) hi_val++;
            if (busy) hi_busy++;
        end
        check("empty_no_read",  32'(hi_rd),   32'd0);
        check("empty_no_valid", 32'(hi_val),  32'd0);
        check("empty_no_busy",  32'(hi_busy), 32'd0);

        // Single word, latency and symbol order
        out_ready = 1'b1;
        clear_rx();
        push(32'h11223344);
        tick();
        check("lat_read_k1", 32'(fifo_read), 32'd1);
        tick();
        check("lat_read_k2", 32'(fifo_read), 32'd0);
        check("lat_valid_k2", 32'(out_valid), 32'd0);
        tick();
        check("lat_valid_k3", 32'(out_valid), 32'd1);
        wait_rx(4, 20, "w1_count");
        check_word("w1", 32'h11223344, 0);
        if (rx_cyc.size() >= 4) check("w1_consecutive", 32'(rx_cyc[3] - rx_cyc[0]), 32'd3);
        repeat (5) tick();
        check("w1_idle_busy", 32'(busy), 32'd0);
        check("w1_reads", 32'(rd_pulses), 32'd1);

        // Eight back-to-back words
        clear_rx();
        for (int w = 0; w < 8; w++) push(32'(w));
        wait_rx(32, 300, "b2b_count");
        for (int w = 0; w < 8; w++) check_word($sformatf("b2b_w%0d", w), 32'(w), 4*w);
        gap_errs = 0;
        for (int i = 1; i < rx_cyc.size(); i++) begin
            if (rx_cyc[i] - rx_cyc[i-1] != (((i % 4) == 0) ? 3 : 1)) gap_errs++;
        end
        check("b2b_spacing", 32'(gap_errs), 32'd0);
        repeat (5) tick();
        check("b2b_reads", 32'(rd_pulses), 32'd8);
        check("b2b_pulse_width", 32'(wide_pulses), 32'd0);
        check("b2b_idle_busy", 32'(busy), 32'd0);

        // Back-pressure on the second symbol
        clear_rx();
        push(32'hA5B6C7D8);
        wait_rx(1, 20, "stall_first");
        out_ready = 1'b0;
        stall_errs = 0;
        repeat (5) begin
            tick();
            if (out_data !== 8'hB6 || out_valid !== 1'b1 || out_last !== 1'b0) stall_errs++;
        end
        check("stall_hold", 32'(stall_errs), 32'd0);
        out_ready = 1'b1;
        wait_rx(4, 20, "stall_count");
        repeat (5) tick();
        check("stall_no_dup", 32'(rx_data.size()), 32'd4);
        check_word("stall", 32'hA5B6C7D8, 0);

        // Enable dropped mid-word with data still queued
        clear_rx();
        push(32'h8);
        push(32'h9);
        wait_rx(1, 20, "en_first");
        enable = 1'b0;
        wait_rx(4, 20, "en_count");
        repeat (10) tick();
        check_word("en_drop", 32'h8, 0);
        check("en_reads", 32'(rd_pulses), 32'd1);
        check("en_idle_busy", 32'(busy), 32'd0);
        check("en_fifo_left", 32'(fifo_q.size()), 32'd1);

        // Reset during symbol 2, then a clean word
        fifo_q.delete();
        fifo_empty = 1'b1;
        clear_rx();
        enable = 1'b1;
        push(32'hCAFEF00D);
        wait_rx(2, 20, "rst_mid_first");
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        check("rstm_fifo_read", 32'(fifo_read), 32'd0);
        check("rstm_out_valid", 32'(out_valid), 32'd0);
        check("rstm_out_last",  32'(out_last),  32'd0);
        check("rstm_busy",      32'(busy),      32'd0);
        check("rstm_out_data",  32'(out_data),  32'd0);
        reset = 1'b0;
        clear_rx();
        enable = 1'b1;
        push(32'h9);
        wait_rx(4, 20, "post_rst_count");
        repeat (5) tick();
        check("post_rst_no_extra", 32'(rx_data.size()), 32'd4);
        check_word("post_rst", 32'h9, 0);

        // Run-wide invariants
        check("no_underflow", 32'(underflows), 32'd0);
        check("pulse_width_all", 32'(wide_pulses), 32'd0);
`ifdef FIFO_SER_PARITY_EN
        check("parity", 32'(parity_errs), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_word_serializer.md
FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
- REQ-001: The block SHALL have one clock, `clock`; reset is synchronous and active-high, named `reset`.
- REQ-002: Parameter `DATA_W`, default 32, FIFO word width; SHALL be a multiple of `BYTE_W`.
- REQ-003: Parameter `BYTE_W`, default 8, output symbol width.
- REQ-004: `clock` input 1: rising-edge clock for all state.
- REQ-005: `reset` input 1: synchronous, active-high reset.
- REQ-006: `enable` input 1: permits new FIFO reads when high.
- REQ-007: `fifo_empty` input 1: empty flag of the upstream FIFO.
- REQ-008: `fifo_read` output 1: read strobe to the FIFO, driven from a register.
- REQ-009: `fifo_data` input `DATA_W`: FIFO read data, valid the cycle after the FIFO samples `fifo_read`.
- REQ-010: `out_data` output `BYTE_W`: current output symbol.
- REQ-011: `out_valid` output 1: `out_data` is valid.
- REQ-012: `out_ready` input 1: the consumer accepts a symbol when this and `out_valid` are both high.
- REQ-013: `out_last` output 1: marks the final symbol of a word.
- REQ-014: `busy` output 1: high in any state other than IDLE.

Function
- REQ-015: The FSM SHALL have states IDLE, READ, WAIT and SHIFT, with `NB = DATA_W/BYTE_W` symbols per word.
- REQ-016: IDLE -> READ when `enable` is high and `fifo_empty` is low; otherwise stay in IDLE.
- REQ-017: In READ, `fifo_read` SHALL be high for exactly one cycle, then the FSM moves to WAIT unconditionally.
- REQ-018: In WAIT, the block SHALL capture `fifo_data` into the shift register, clear the symbol counter, then move to SHIFT.
- REQ-019: In SHIFT, `out_valid` SHALL be high and `out_data` SHALL equal the most-significant unsent symbol (MSB-first); `out_last` is high only when the counter equals `NB-1`.
- REQ-020: While `out_valid` is high and `out_ready` is low, `out_data` and `out_last` SHALL hold stable.
- REQ-021: On acceptance of a non-last symbol, the block SHALL shift by `BYTE_W` and increment the counter.
- REQ-022: On acceptance of the last symbol: go to READ if `enable` is high and `fifo_empty` is low, else go to IDLE.
- REQ-023: Latency SHALL be: IDLE trigger seen in cycle k -> `fifo_read` high in k+1 -> `out_valid` high in k+3.
- REQ-024: If `enable` falls mid-word, the current word SHALL complete; no further read is issued.
- REQ-025: `fifo_read` SHALL never be asserted while `fifo_empty` is high at the decision edge (underflow protection).
- REQ-026: `fifo_read` SHALL never be asserted outside the READ state, so at most one word is in flight.

Reset
- REQ-027: On `reset` high at a clock edge: state SHALL be IDLE and `fifo_read`, `out_valid`, `out_last`, `busy` SHALL be 0.
- REQ-028: On the same reset edge, `out_data`, the shift register and the counter SHALL be 0.
- REQ-029: Reset SHALL have priority over all other inputs; reset mid-word discards the partially sent word.

Configuration
- REQ-030: With macro `FIFO_SER_PARITY_EN` defined, the block SHALL add output `out_parity` (1 bit) equal to the XOR reduction of `out_data`, held stable under the same rules as `out_data`.
- REQ-031: Without `FIFO_SER_PARITY_EN`, the `out_parity` port and its logic SHALL be absent; all other behaviour is identical.

Structure
- REQ-032: Package `fifo_ser_pkg` SHALL hold the state enumeration (IDLE, READ, WAIT, SHIFT) and the default `DATA_W`/`BYTE_W` constants.
- REQ-033: The shift register and symbol counter SHALL live in sub-module `fifo_ser_shifter` (inputs load/shift, outputs symbol/last); the FSM stays in the top module.

Verification
- REQ-034: Reset, then `fifo_empty`=1 and `enable`=1 for 10 cycles -> `fifo_read` stays 0, `out_valid` stays 0, `busy`=0.
- REQ-035: One word 32'h11223344 with `out_ready`=1 -> symbols 8'h11, 8'h22, 8'h33, 8'h44 on consecutive cycles; `out_last` high only on 8'h44; `out_valid` first high 3 cycles after trigger.
- REQ-036: Words 32'h0..32'h7 back-to-back with `out_ready`=1 -> 32 symbols in order; exactly 8 `fifo_read` pulses, each 1 cycle wide; READ re-entered directly from SHIFT.
- REQ-037: `out_ready` low for 5 cycles on the second symbol of 32'hA5B6C7D8 -> `out_data` holds 8'hB6 throughout the stall; no symbol lost or duplicated.
- REQ-038: `enable` dropped during symbol 1 of 32'h8, FIFO still non-empty -> word 32'h8 completes, then IDLE with no further `fifo_read`.
- REQ-039: `reset` asserted during symbol 2 -> next cycle IDLE with all outputs 0; a later word 32'h9 serializes correctly. With `FIFO_SER_PARITY_EN`, `out_parity` matches XOR of each symbol.
